// File: rtl/sm3_pkg.sv
// SM3 padding front-end: shared constants, state encoding
// and strobe decoding helpers.
package sm3_pkg;

  localparam int SM3_BLK_W = 512;
  localparam int SM3_WORDS = 16;
  localparam int SM3_LEN_W = 64;
  localparam logic [7:0] SM3_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    TAIL
  } sm3_state_e;

  typedef struct packed {
    logic       ok;
    logic [2:0] cnt;
  } strb_info_t;

  // Illegal patterns decode as a full beat.
  function automatic strb_info_t strb_to_count(
    input logic [3:0] strb
  );
    strb_info_t r;
    r.ok  = 1'b1;
    r.cnt = 3'd4;
    case (strb)
      4'b0000: r.cnt = 3'd0;
      4'b1000: r.cnt = 3'd1;
      4'b1100: r.cnt = 3'd2;
      4'b1110: r.cnt = 3'd3;
      4'b1111: r.cnt = 3'd4;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm3_pad_word.sv
// Masks invalid byte lanes of a beat and drops the 0x80
// marker into the first free lane when asked.
module sm3_pad_word
  import sm3_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  input  logic        pad,
  output logic [31:0] word
);

  strb_info_t info;

  assign info = strb_to_count(strb);

  always_comb begin
    word = '0;
    for (int i = 0; i < 4; i++) begin
      if (strb[3-i])
        word[31-8*i -: 8] = data[31-8*i -: 8];
      else if (pad && info.cnt == 3'(i))
        word[31-8*i -: 8] = SM3_PAD_BYTE;
    end
  end

endmodule

// File: rtl/sm3_pad_axis.sv
// SM3 message padder: 32-bit AXI-Stream bytes in,
// padded 512-bit blocks with first/last flags out.
module sm3_pad_axis
  import sm3_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int BLKWIDTH  = 512
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATAWIDTH-1:0] S_AXIS_TDATA,
  input  logic [3:0]           S_AXIS_TSTRB,
  input  logic                 S_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [BLKWIDTH-1:0]  blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 blk_first,
  output logic                 blk_last,
  output logic                 err_strb
);

  sm3_state_e state_q, state_d;

  logic [31:0]          blk_q [SM3_WORDS];
  logic [3:0]           idx_q;
  logic [SM3_LEN_W-1:0] len_q;
  logic [SM3_LEN_W-1:0] len_nx;
  logic                 first_q;
  logic                 last_q;
  logic                 tail_q;
  logic                 pad_q;
  logic                 tready_q;
  logic                 err_q;

  strb_info_t  info;
  logic        beat;
  logic        bad_strb;
  logic [2:0]  cnt;
  logic [3:0]  strb_n;
  logic [6:0]  total;
  logic [31:0] pw_word;

  assign info = strb_to_count(S_AXIS_TSTRB);
  assign beat = S_AXIS_TVALID && tready_q;

  always_comb begin
    cnt      = 3'd4;
    strb_n   = 4'hf;
    bad_strb = 1'b0;
    if (S_AXIS_TLAST) begin
      bad_strb = !info.ok;
      if (info.ok) begin
        cnt    = info.cnt;
        strb_n = S_AXIS_TSTRB;
      end
    end else begin
      bad_strb = (S_AXIS_TSTRB != 4'hf);
    end
  end

  assign total  = {1'b0, idx_q, 2'b00} + {4'd0, cnt};
  assign len_nx = len_q + {58'd0, cnt, 3'd0};

  sm3_pad_word u_pad_word (
    .data (S_AXIS_TDATA),
    .strb (strb_n),
    .pad  (S_AXIS_TLAST),
    .word (pw_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (beat && (S_AXIS_TLAST || idx_q == 4'd15))
          state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_q)      state_d = COLLECT;
          else if (tail_q) state_d = TAIL;
          else             state_d = COLLECT;
        end
      end
      TAIL:    state_d = EMIT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SM3_WORDS; i++)
        blk_q[i] <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      tail_q   <= 1'b0;
      pad_q    <= 1'b0;
      tready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tready_q <= (state_d == COLLECT);
      err_q    <= beat && bad_strb;
      unique case (state_q)
        COLLECT: begin
          if (beat) begin
            len_q        <= len_nx;
            blk_q[idx_q] <= pw_word;
            idx_q        <= idx_q + 4'd1;
            last_q       <= 1'b0;
            tail_q       <= 1'b0;
            if (S_AXIS_TLAST) begin
              idx_q <= '0;
              // A full last beat pushes the marker into the next word.
              if (cnt == 3'd4 && idx_q != 4'd15)
                blk_q[idx_q + 4'd1] <= {SM3_PAD_BYTE, 24'd0};
              if (total <= 7'd55) begin
                blk_q[14] <= len_nx[63:32];
                blk_q[15] <= len_nx[31:0];
                last_q    <= 1'b1;
              end else begin
                tail_q <= 1'b1;
                pad_q  <= (total > 7'd63);
              end
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            for (int i = 0; i < SM3_WORDS; i++)
              blk_q[i] <= '0;
            first_q <= 1'b0;
            if (last_q) begin
              first_q <= 1'b1;
              len_q   <= '0;
            end
          end
        end
        TAIL: begin
          blk_q[0]  <= pad_q ? {SM3_PAD_BYTE, 24'd0} : 32'd0;
          blk_q[14] <= len_q[63:32];
          blk_q[15] <= len_q[31:0];
          last_q    <= 1'b1;
          tail_q    <= 1'b0;
          pad_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < SM3_WORDS; i++)
      blk_data[BLKWIDTH-1-32*i -: 32] = blk_q[i];
  end

  assign blk_valid     = (state_q == EMIT);
  assign blk_first     = blk_valid && first_q;
  assign blk_last      = blk_valid && last_q;
  assign S_AXIS_TREADY = tready_q;
  assign err_strb      = err_q;

endmodule

// File: doc/sm3_pad_axis.md
Name: sm3_pad_axis

Overview:
- Upstream stage of the SM3 hash path.
- Accepts a byte message as a 32-bit AXI-Stream, applies SM3 padding (0x80, zero fill, 64-bit big-endian bit length), and emits complete 512-bit message blocks to the compression core.
- Each block carries first/last flags so the core knows when to load the IV and when the digest is final.
- Single output block buffer with a valid/ready handshake toward the core.

Parameters:
DATAWIDTH, 32, input stream width in bits; fixed, other values unsupported.
BLKWIDTH, 512, output block width in bits; fixed.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  32  message bytes, big-endian; bits [31:24] are the first byte
S_AXIS_TSTRB  in  4  byte strobe; must be 4'b1111 on non-last beats
S_AXIS_TLAST  in  1  last beat of the message
S_AXIS_TVALID  in  1  input beat valid
S_AXIS_TREADY  out  1  input beat accepted when high with TVALID
blk_data  out  512  padded block; word 0 in bits [511:480]
blk_valid  out  1  block available
blk_ready  in  1  core accepts block
blk_first  out  1  block is the first of its message
blk_last  out  1  block is the final block (length included)
err_strb  out  1  one-cycle pulse on an illegal strobe pattern

Behaviour:
- Reset (async, rstn=0): all outputs 0. State=COLLECT, word index=0, bit length=0, first flag=1. Buffer cleared.
- Clock/reset: one clock; reset is asynchronous and active-low, ports named clk and rstn.
- Legal last-beat strobes, giving 0..4 valid bytes, MSB-aligned: 0000, 1000, 1100, 1110, 1111.
  - Any other last-beat strobe, or a non-1111 strobe on a non-last beat, is treated as 1111 and pulses err_strb.
- Bit-length counter is 64 bits, incremented by 8×(valid bytes) per beat, wrapping mod 2^64.
- Invalid bytes in an accepted beat are written as zero.
- S_AXIS_TREADY = 1 only in COLLECT while blk_valid=0.
- States:
  - COLLECT: each accepted beat writes word[idx] and increments idx.
    - Non-last beat at idx=15: go to EMIT with last=0.
    - TLAST beat with valid bytes n:
      - Write 0x80 at byte position 4·idx+n and zero everything after it.
      - If the total bytes in the block are ≤55: write the length into words 14–15 and go to EMIT with last=1.
      - Else if the 0x80 fits (total ≤63): go to EMIT with last=0, then TAIL with pad_pending=0.
      - Else (block exactly full, idx=15, n=4): go to EMIT with last=0, then TAIL with pad_pending=1.
  - EMIT: blk_valid=1 the cycle after the transition beat; blk_data, blk_first and blk_last are held stable until blk_ready.
    - On handshake: clear the buffer and first:=0.
    - If the block was last: first:=1, length:=0, go to COLLECT.
    - If a TAIL is owed: go to TAIL; else go to COLLECT.
  - TAIL: build a block in one cycle: word0 = 0x80000000 if pad_pending else 0, words 1–13 = 0, words 14–15 = length. Go to EMIT with last=1.
- Latency: a block is valid 1 cycle after the beat completing it; a TAIL block is valid 2 cycles after the preceding handshake.
- Empty message (TLAST, TSTRB=0000 at idx=0): one block 0x80000000, zeros, length 0; first=last=1.
- Handshake coinciding with blk_valid rising is legal; the block is accepted in one cycle.
- Deasserting rstn mid-message or mid-EMIT discards everything: blk_valid drops immediately, and the next beat starts a new message.

Decomposition:
- Package sm3_pkg:
  - SM3_BLK_W=512, SM3_WORDS=16, SM3_LEN_W=64, SM3_PAD_BYTE=8'h80.
  - State enum {COLLECT, EMIT, TAIL}.
  - Function strb_to_count.
- One natural sub-module, sm3_pad_word: combinational. Given a data word, a strobe and a pad-insert flag, it produces the masked word with 0x80 inserted at the correct byte lane.

Test Plan:
1. "abc": one beat 0x61626300, strb 1110, last → one block 61626380, 13×0, 00000000, 00000018; first=last=1.
2. 56-byte message, 14 beats 0x61626364, final strb 1111 → block0 = data + 0x80000000 at word 14, word 15 = 0, last=0; then block1 = 14×0 + length 0x1C0, first=0, last=1.
3. 64-byte message, 16 full beats → block0 is raw data with last=0; block1 = 0x80000000, 13×0, 0, 0x200; last=1.
4. Empty message (TSTRB=0000, last) → 80000000, 14×0, 0; first=last=1. Also an illegal strobe 0101 on a last beat → err_strb pulse, treated as 4 bytes.
5. Hold blk_ready=0 for 20 cycles during "abc" followed by a second message → TREADY=0 and blk_data stable throughout. After release, the second message has blk_first=1.
6. Assert rstn low after 7 beats, then send "abc" → output exactly matches scenario 1; no stale words appear.
